// File: rtl/d_stream_source.sv
// Strided-word token source for the valid/ready interface. Each burst emits cfg_count words
// starting at cfg_base and stepping by cfg_stride. The final word carries the LAST flag.
module d_stream_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [DATA_WIDTH-1:0] cfg_base,
  input  logic [DATA_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic                  cfg_abort,
  output logic [DATA_WIDTH:0]   io_dout,
  output logic                  io_dout_v,
  input  logic                  io_dout_r,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sent
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] payload_q, stride_q;
  logic                  last_q;
  logic [CNT_WIDTH-1:0]  remaining_q, sent_q;
  logic                  start_ok, xfer, final_xfer;

  assign start_ok   = (state_q == StIdle) && cfg_start;
  assign xfer       = (state_q == StRun) && io_dout_r;
  assign final_xfer = xfer && (remaining_q == CNT_WIDTH'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = (cfg_count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (cfg_abort || final_xfer) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    io_dout_v = (state_q == StRun);
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
  end

  // The token register only advances while another word will follow, so io_dout keeps the
  // last driven token once valid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      payload_q   <= '0;
      stride_q    <= '0;
      last_q      <= 1'b0;
      remaining_q <= '0;
      sent_q      <= '0;
    end else if (start_ok) begin
      stride_q    <= cfg_stride;
      remaining_q <= cfg_count;
      sent_q      <= '0;
      if (cfg_count != '0) begin
        payload_q <= cfg_base;
        last_q    <= (cfg_count == CNT_WIDTH'(1));
      end
    end else if (xfer) begin
      sent_q      <= sent_q + CNT_WIDTH'(1);
      remaining_q <= remaining_q - CNT_WIDTH'(1);
      if (!final_xfer && !cfg_abort) begin
        payload_q <= payload_q + stride_q;
        last_q    <= (remaining_q == CNT_WIDTH'(2));
      end
    end
  end

  assign io_dout = {last_q, payload_q};
  assign sent    = sent_q;

endmodule

// File: tb/tb_d_stream_source.sv
// Self-checking bench for d_stream_source: table-driven bursts, corner sequences and random
// bursts checked against an arithmetic token model (word i = base + i*stride).
module tb_d_stream_source;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [DW-1:0] cfg_base;
  logic [DW-1:0] cfg_stride;
  logic [CW-1:0] cfg_count;
  logic          cfg_abort;
  logic [DW:0]   io_dout;
  logic          io_dout_v;
  logic          io_dout_r;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent;

  int n_checks = 0;
  int n_fail   = 0;

  d_stream_source #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_base  (cfg_base),
    .cfg_stride(cfg_stride),
    .cfg_count (cfg_count),
    .cfg_abort (cfg_abort),
    .io_dout   (io_dout),
    .io_dout_v (io_dout_v),
    .io_dout_r (io_dout_r),
    .busy      (busy),
    .done      (done),
    .sent      (sent)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] base;
    logic [DW-1:0] stride;
    int            count;
    int            mode;      // 0: ready=1, 1: ready 1,0,0 repeating, 2: depth-32 FIFO sink
    int            abort_at;  // abort on the transfer of word index abort_at, -1 = none
    int            exp_sent;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    io_dout_r = 1'b0;
  endtask

  // After a detected error, resynchronise the DUT so later bursts still run meaningfully.
  task automatic recover();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_burst(input logic [DW-1:0] base, input logic [DW-1:0] stride,
                           input int count, input int mode, input int abort_at,
                           input int exp_sent);
    int            acc;
    int            cyc;
    int            limit;
    int            fifo_cnt;
    int            fails_before;
    logic          exp_done;
    logic          r;
    logic          abort_now;
    logic [DW:0]   exp_tok;
    logic [DW-1:0] word;
    acc      = 0;
    cyc      = 0;
    fifo_cnt = 0;
    limit    = count * 8 + 40;
    cfg_base   = base;
    cfg_stride = stride;
    cfg_count  = count[CW-1:0];
    cfg_abort  = 1'b0;
    io_dout_r  = 1'b0;
    cfg_start  = 1'b1;
    exp_done   = (count == 0);
    @(negedge clock);
    cfg_start = 1'b0;
    forever begin
      fails_before = n_fail;
      if (exp_done) begin
        check("done_pulse", 64'(done), 64'd1);
        check("valid_off_at_done", 64'(io_dout_v), 64'd0);
        check("sent_final", 64'(sent), 64'(exp_sent));
        idle_inputs();
        @(negedge clock);
        check("done_one_cycle", 64'({done, busy, io_dout_v}), 64'd0);
        check("sent_hold", 64'(sent), 64'(exp_sent));
        if (n_fail != fails_before) recover();
        break;
      end
      if (cyc >= limit) begin
        check("burst_timeout", 64'd1, 64'd0);
        recover();
        break;
      end
      word    = base + stride * DW'(acc);
      exp_tok = {(acc == count - 1), word};
      check("valid", 64'(io_dout_v), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("token", 64'(io_dout), 64'(exp_tok));
      if (n_fail != fails_before) begin
        recover();
        break;
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc % 3 == 0);
      else r = (fifo_cnt < 32);
      abort_now = (abort_at >= 0) && (acc == abort_at) && r;
      io_dout_r = r;
      cfg_abort = abort_now;
      // A second start while running must be ignored.
      cfg_start = (cyc == 1);
      if (cyc == 1) begin
        cfg_base  = ~base;
        cfg_count = 16'd5;
      end
      if (r) begin
        acc++;
        fifo_cnt++;
        if (acc == count || abort_now) exp_done = 1'b1;
      end
      if (mode == 2 && fifo_cnt > 0 && $urandom_range(0, 3) == 0) fifo_cnt--;
      cyc++;
      @(negedge clock);
      cfg_start = 1'b0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int cnt;
    int ab;
    vecs[0] = '{base: 32'd5,          stride: 32'd3, count: 4,  mode: 0, abort_at: -1, exp_sent: 4};
    vecs[1] = '{base: 32'd5,          stride: 32'd3, count: 4,  mode: 1, abort_at: -1, exp_sent: 4};
    vecs[2] = '{base: 32'd9,          stride: 32'd1, count: 0,  mode: 0, abort_at: -1, exp_sent: 0};
    vecs[3] = '{base: 32'hFFFF_FFFE,  stride: 32'd1, count: 3,  mode: 0, abort_at: -1, exp_sent: 3};
    vecs[4] = '{base: 32'd7,          stride: 32'd2, count: 10, mode: 0, abort_at: 3,  exp_sent: 4};
    vecs[5] = '{base: 32'h1234_5678,  stride: 32'd0, count: 1,  mode: 0, abort_at: -1, exp_sent: 1};
    vecs[6] = '{base: 32'd100,        stride: 32'h8000_0001, count: 40, mode: 2, abort_at: -1,
                exp_sent: 40};
    vecs[7] = '{base: 32'd3,          stride: 32'hFFFF_FFFF, count: 9, mode: 1, abort_at: 5,
                exp_sent: 6};

    idle_inputs();
    cfg_base   = '0;
    cfg_stride = '0;
    cfg_count  = '0;
    reset      = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_dout", 64'(io_dout), 64'd0);
    check("reset_flags", 64'({io_dout_v, busy, done}), 64'd0);
    check("reset_sent", 64'(sent), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Abort while idle is ignored.
    cfg_abort = 1'b1;
    @(negedge clock);
    cfg_abort = 1'b0;
    check("abort_idle_ignored", 64'({io_dout_v, busy, done}), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].base, vecs[i].stride, vecs[i].count, vecs[i].mode, vecs[i].abort_at,
                vecs[i].exp_sent);
    end

    // Reset mid-burst with valid high.
    cfg_base   = 32'd100;
    cfg_stride = 32'd1;
    cfg_count  = 16'd10;
    cfg_start  = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    check("pre_reset_token", 64'({io_dout_v, io_dout}), 64'({1'b1, 1'b0, 32'd100}));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midburst_reset_dout", 64'(io_dout), 64'd0);
    check("midburst_reset_flags", 64'({io_dout_v, busy, done}), 64'd0);
    check("midburst_reset_sent", 64'(sent), 64'd0);
    @(negedge clock);
    check("post_reset_idle", 64'({io_dout_v, busy, done}), 64'd0);
    run_burst(32'd200, 32'd7, 3, 0, -1, 3);

    for (int i = 0; i < 25; i++) begin
      cnt = $urandom_range(0, 12);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt) : -1;
      run_burst($urandom, $urandom, cnt, $urandom_range(0, 2), ab,
                (ab >= 0 && ab < cnt) ? ab + 1 : cnt);
    end

    // Maximum burst length must complete without counter wrap.
    run_burst(32'd1, 32'd1, 65535, 0, -1, 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
